out_port_fifo: RTL

OUT_PORT_FIFO -- requirements
Module: out_port_fifo

---
 rtl/out_port_pkg.sv | 10 +
 rtl/out_port_mem.sv | 23 ++
 rtl/out_port_fifo.sv | 84 ++++++++
 3 files changed

// File: rtl/out_port_pkg.sv
// Shared constants and helpers for the CPU output-port FIFO.
package out_port_pkg;
  localparam int DATA_W    = 8;
  localparam int DEPTH_DEF = 8;

  // Occupancy needs one bit beyond the pointer width so DEPTH itself is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/out_port_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
module out_port_mem
  import out_port_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/out_port_fifo.sv
// Output-port FIFO capturing CPU output bus writes (strobe or change-detect) for a consumer.
module out_port_fifo
  import out_port_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int CHANGE_MODE = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         cpu_out,
  input  logic                      cpu_wr,
  output logic [DATA_W-1:0]         dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      overflow,
  input  logic                      ovf_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] last_seen_q, last_seen_d;
  logic [DATA_W-1:0] rd_data;
  logic              push_evt, push, pop, ovf_evt;

  assign dout_valid = (count_q != '0);
  assign full       = (count_q == DEPTH_C);
  assign pop        = dout_valid & dout_ready;
  assign push_evt   = (CHANGE_MODE != 0) ? (cpu_out != last_seen_q) : cpu_wr;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push       = push_evt & (~full | pop);
  assign ovf_evt    = push_evt & full & ~pop;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    last_seen_d = cpu_out;
    ovf_d       = ovf_evt | (ovf_q & ~ovf_clr);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      last_seen_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      last_seen_q <= last_seen_d;
    end
  end

  out_port_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clock   (clock),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (cpu_out),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign dout     = dout_valid ? rd_data : '0;
  assign count    = count_q;
  assign overflow = ovf_q;
endmodule
